// File: rtl/fpu_dispatcher.sv
// FP request dispatcher: executes sign-inject/compare/min-max/classify in-block
// and steers add/mul/div/convert requests to external units over a/b/z handshakes.
module fpu_dispatcher #(
  parameter int unsigned          EXP_W      = 8,
  parameter int unsigned          FRAC_W     = 23,
  parameter int unsigned          NUM_UNITS  = 5,
  parameter logic [NUM_UNITS-1:0] UNIT_HAS_B = NUM_UNITS'(5'b00111),
  localparam int unsigned         WIDTH      = 1 + EXP_W + FRAC_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [3:0]                 req_op,
  input  logic [WIDTH-1:0]           req_a,
  input  logic [WIDTH-1:0]           req_b,
  input  logic                       req_stb,
  output logic                       req_ack,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [1:0]                 rsp_flags,
  output logic                       rsp_stb,
  input  logic                       rsp_ack,
  output logic [WIDTH-1:0]           unit_a,
  output logic [WIDTH-1:0]           unit_b,
  output logic [NUM_UNITS-1:0]       unit_a_stb,
  input  logic [NUM_UNITS-1:0]       unit_a_ack,
  output logic [NUM_UNITS-1:0]       unit_b_stb,
  input  logic [NUM_UNITS-1:0]       unit_b_ack,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_z,
  input  logic [NUM_UNITS-1:0]       unit_z_stb,
  output logic [NUM_UNITS-1:0]       unit_z_ack
);

  typedef enum logic [3:0] {
    OP_FADD    = 4'b0000, OP_FSUB   = 4'b0001, OP_FMUL   = 4'b0010,
    OP_FDIV    = 4'b0011, OP_FCVT_SW = 4'b0100, OP_FCVT_WS = 4'b0101,
    OP_FSGNJ   = 4'b0110, OP_FSGNJN = 4'b0111, OP_FEQ    = 4'b1000,
    OP_FLT     = 4'b1001, OP_FLE    = 4'b1010, OP_FMIN   = 4'b1011,
    OP_FMAX    = 4'b1100, OP_FCLASS = 4'b1101, OP_FSGNJX = 4'b1110,
    OP_ILLEGAL = 4'b1111
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_A, S_SEND_B, S_WAIT_Z, S_RESP
  } state_e;

  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  state_e            state, state_nxt;
  logic [2:0]        unit_sel;
  logic [2:0]        req_unit;
  logic              req_slow, unit_missing, illegal_resp, accept;
  logic              sel_a_ack, sel_b_ack, sel_z_stb, sel_has_b;
  logic [WIDTH-1:0]  sel_z;
  logic [WIDTH-1:0]  fast_data;
  logic              fast_nv;

  function automatic logic is_nan(input logic [WIDTH-1:0] x);
    return (&x[MSB-1:FRAC_W]) && (|x[FRAC_W-1:0]);
  endfunction

  function automatic logic is_snan(input logic [WIDTH-1:0] x);
    return is_nan(x) && !x[FRAC_W-1];
  endfunction

  function automatic logic is_zero(input logic [WIDTH-1:0] x);
    return ~|x[MSB-1:0];
  endfunction

  // Strict numeric less-than for non-NaN operands; +0 and -0 are equal here.
  function automatic logic num_lt(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (is_zero(x) && is_zero(y)) return 1'b0;
    if (x[MSB] != y[MSB])         return x[MSB];
    if (x[MSB])                   return x[MSB-1:0] > y[MSB-1:0];
    return x[MSB-1:0] < y[MSB-1:0];
  endfunction

  function automatic logic num_eq(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (is_zero(x) && is_zero(y)) || (x == y);
  endfunction

  always_comb begin
    req_slow = 1'b1;
    req_unit = '0;
    case (req_op)
      OP_FADD, OP_FSUB: req_unit = 3'd0;
      OP_FMUL:          req_unit = 3'd1;
      OP_FDIV:          req_unit = 3'd2;
      OP_FCVT_SW:       req_unit = 3'd3;
      OP_FCVT_WS:       req_unit = 3'd4;
      default:          req_slow = 1'b0;
    endcase
  end

  assign unit_missing = req_slow && (32'(req_unit) >= NUM_UNITS);
  assign illegal_resp = (req_op == OP_ILLEGAL) || unit_missing;
  assign accept       = (state == S_IDLE) && req_stb;

  always_comb begin
    logic       a_nan, b_nan, any_snan, both_zero;
    logic [9:0] cls;
    fast_data = '0;
    fast_nv   = 1'b0;
    cls       = '0;
    a_nan     = is_nan(req_a);
    b_nan     = is_nan(req_b);
    any_snan  = is_snan(req_a) || is_snan(req_b);
    both_zero = is_zero(req_a) && is_zero(req_b);
    case (req_op)
      OP_FSGNJ:  fast_data = {req_b[MSB], req_a[MSB-1:0]};
      OP_FSGNJN: fast_data = {~req_b[MSB], req_a[MSB-1:0]};
      OP_FSGNJX: fast_data = {req_a[MSB] ^ req_b[MSB], req_a[MSB-1:0]};
      OP_FEQ: begin
        fast_data = WIDTH'(!a_nan && !b_nan && num_eq(req_a, req_b));
        fast_nv   = any_snan;
      end
      OP_FLT: begin
        fast_data = WIDTH'(!a_nan && !b_nan && num_lt(req_a, req_b));
        fast_nv   = a_nan || b_nan;
      end
      OP_FLE: begin
        fast_data = WIDTH'(!a_nan && !b_nan && (num_lt(req_a, req_b) || num_eq(req_a, req_b)));
        fast_nv   = a_nan || b_nan;
      end
      // Signed zeros are ordered (-0 < +0) only for min/max selection.
      OP_FMIN, OP_FMAX: begin
        fast_nv = any_snan;
        if (a_nan && b_nan)  fast_data = CANON_NAN;
        else if (a_nan)      fast_data = req_b;
        else if (b_nan)      fast_data = req_a;
        else if (req_op == OP_FMIN)
          fast_data = (num_lt(req_a, req_b) || (both_zero && req_a[MSB])) ? req_a : req_b;
        else
          fast_data = (num_lt(req_b, req_a) || (both_zero && !req_a[MSB])) ? req_a : req_b;
      end
      OP_FCLASS: begin
        if (a_nan)                       cls[is_snan(req_a) ? 8 : 9] = 1'b1;
        else if (&req_a[MSB-1:FRAC_W])   cls[req_a[MSB] ? 0 : 7] = 1'b1;
        else if (is_zero(req_a))         cls[req_a[MSB] ? 3 : 4] = 1'b1;
        else if (~|req_a[MSB-1:FRAC_W])  cls[req_a[MSB] ? 2 : 5] = 1'b1;
        else                             cls[req_a[MSB] ? 1 : 6] = 1'b1;
        fast_data = WIDTH'(cls);
      end
      default: fast_data = '0;
    endcase
  end

  always_comb begin
    sel_a_ack = 1'b0;
    sel_b_ack = 1'b0;
    sel_z_stb = 1'b0;
    sel_has_b = 1'b0;
    sel_z     = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (unit_sel == 3'(i)) begin
        sel_a_ack = unit_a_ack[i];
        sel_b_ack = unit_b_ack[i];
        sel_z_stb = unit_z_stb[i];
        sel_has_b = UNIT_HAS_B[i];
        sel_z     = unit_z[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ack    = 1'b0;
    rsp_stb    = 1'b0;
    unit_a_stb = '0;
    unit_b_stb = '0;
    unit_z_ack = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      unit_a_stb[i] = (state == S_SEND_A) && (unit_sel == 3'(i));
      unit_b_stb[i] = (state == S_SEND_B) && (unit_sel == 3'(i));
      unit_z_ack[i] = (state == S_WAIT_Z) && (unit_sel == 3'(i));
    end
    case (state)
      S_IDLE: begin
        req_ack = 1'b1;
        if (req_stb) state_nxt = (req_slow && !unit_missing) ? S_SEND_A : S_RESP;
      end
      S_SEND_A: if (sel_a_ack) state_nxt = sel_has_b ? S_SEND_B : S_WAIT_Z;
      S_SEND_B: if (sel_b_ack) state_nxt = S_WAIT_Z;
      S_WAIT_Z: if (sel_z_stb) state_nxt = S_RESP;
      S_RESP: begin
        rsp_stb = 1'b1;
        if (rsp_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      unit_sel  <= '0;
      unit_a    <= '0;
      unit_b    <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        unit_sel <= req_unit;
        unit_a   <= req_a;
        unit_b   <= (req_op == OP_FSUB) ? {~req_b[MSB], req_b[MSB-1:0]} : req_b;
        if (illegal_resp) begin
          rsp_data  <= '0;
          rsp_flags <= 2'b11;
        end else if (!req_slow) begin
          rsp_data  <= fast_data;
          rsp_flags <= {1'b0, fast_nv};
        end
      end
      if ((state == S_WAIT_Z) && sel_z_stb) begin
        rsp_data  <= sel_z;
        rsp_flags <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_dispatcher.sv
// Bench for fpu_dispatcher: directed and random requests against a
// value-ordering reference model, with bench-driven stub execution units.
module tb_fpu_dispatcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic [3:0]   req_op;
  logic [31:0]  req_a, req_b;
  logic         req_stb, req_ack;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_flags;
  logic         rsp_stb, rsp_ack;
  logic [31:0]  unit_a, unit_b;
  logic [4:0]   unit_a_stb, unit_a_ack, unit_b_stb, unit_b_ack, unit_z_stb, unit_z_ack;
  logic [159:0] unit_z;

  logic [3:0]   r3_op;
  logic [31:0]  r3_a, r3_b, r3_data, r3_ua, r3_ub;
  logic         r3_stb, r3_ack, r3_rsp_stb, r3_rsp_ack;
  logic [1:0]   r3_flags;
  logic [2:0]   r3_uas, r3_uaa, r3_ubs, r3_uba, r3_uzs, r3_uza;
  logic [95:0]  r3_uz;

  int errors = 0;
  int checks = 0;

  fpu_dispatcher dut (
    .clk(clk), .reset_n(reset_n),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_stb(rsp_stb), .rsp_ack(rsp_ack),
    .unit_a(unit_a), .unit_b(unit_b),
    .unit_a_stb(unit_a_stb), .unit_a_ack(unit_a_ack),
    .unit_b_stb(unit_b_stb), .unit_b_ack(unit_b_ack),
    .unit_z(unit_z), .unit_z_stb(unit_z_stb), .unit_z_ack(unit_z_ack)
  );

  fpu_dispatcher #(.NUM_UNITS(3), .UNIT_HAS_B(3'b111)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .req_op(r3_op), .req_a(r3_a), .req_b(r3_b), .req_stb(r3_stb), .req_ack(r3_ack),
    .rsp_data(r3_data), .rsp_flags(r3_flags), .rsp_stb(r3_rsp_stb), .rsp_ack(r3_rsp_ack),
    .unit_a(r3_ua), .unit_b(r3_ub),
    .unit_a_stb(r3_uas), .unit_a_ack(r3_uaa),
    .unit_b_stb(r3_ubs), .unit_b_ack(r3_uba),
    .unit_z(r3_uz), .unit_z_stb(r3_uzs), .unit_z_ack(r3_uza)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic bit m_snan(input logic [31:0] x);
    return m_nan(x) && (x[22] == 1'b0);
  endfunction

  // Maps a non-NaN float onto the integer line; both zeros land on 0.
  function automatic longint m_key(input logic [31:0] x);
    longint mag;
    mag = longint'({1'b0, x[30:0]});
    return x[31] ? -mag : mag;
  endfunction

  // Returns {flags[1:0], data[31:0]} for fast and illegal ops.
  function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic [1:0]  f;
    bit          an, bn;
    int          cls;
    d = 32'd0; f = 2'b00;
    an = m_nan(a); bn = m_nan(b);
    case (op)
      4'b0110: d = {b[31], a[30:0]};
      4'b0111: d = {~b[31], a[30:0]};
      4'b1110: d = {a[31] ^ b[31], a[30:0]};
      4'b1000: begin
        d = (an || bn) ? 32'd0 : 32'(m_key(a) == m_key(b));
        f[0] = m_snan(a) || m_snan(b);
      end
      4'b1001: begin
        d = (an || bn) ? 32'd0 : 32'(m_key(a) < m_key(b));
        f[0] = an || bn;
      end
      4'b1010: begin
        d = (an || bn) ? 32'd0 : 32'(m_key(a) <= m_key(b));
        f[0] = an || bn;
      end
      4'b1011, 4'b1100: begin
        f[0] = m_snan(a) || m_snan(b);
        if (an && bn)                 d = 32'h7FC0_0000;
        else if (an)                  d = b;
        else if (bn)                  d = a;
        else if (m_key(a) < m_key(b)) d = (op == 4'b1011) ? a : b;
        else if (m_key(b) < m_key(a)) d = (op == 4'b1011) ? b : a;
        else                          d = ((op == 4'b1011) == a[31]) ? a : b;
      end
      4'b1101: begin
        if (an)                       cls = m_snan(a) ? 8 : 9;
        else if (a[30:23] == 8'hFF)   cls = a[31] ? 0 : 7;
        else if (a[30:0] == 31'd0)    cls = a[31] ? 3 : 4;
        else if (a[30:23] == 8'h00)   cls = a[31] ? 2 : 5;
        else                          cls = a[31] ? 1 : 6;
        d = 32'd1 << cls;
      end
      default: begin d = 32'd0; f = 2'b11; end
    endcase
    return {f, d};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 15))
      0:  return 32'h0000_0000;
      1:  return 32'h8000_0000;
      2:  return 32'h7F80_0000;
      3:  return 32'hFF80_0000;
      4:  return 32'h7FC0_0000;
      5:  return 32'h7F80_0001;
      6:  return 32'hFFC0_0001;
      7:  return 32'h0000_0001;
      8:  return 32'h8000_0001;
      9:  return 32'h3F80_0000;
      10: return 32'hBF80_0000;
      11: return {1'b0, 8'h00, 23'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  task automatic fast_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [33:0] e;
    e = model(op, a, b);
    @(negedge clk);
    chk("idle_req_ack", 32'(req_ack), 32'd1);
    req_op = op; req_a = a; req_b = b; req_stb = 1'b1;
    @(posedge clk); #1;
    req_stb = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 4'($urandom);
    for (int k = 0; k <= hold; k++) begin
      chk("fast_rsp_stb", 32'(rsp_stb), 32'd1);
      chk("fast_data", rsp_data, e[31:0]);
      chk("fast_flags", 32'(rsp_flags), 32'(e[33:32]));
      chk("busy_req_ack", 32'(req_ack), 32'd0);
      if (k == hold) rsp_ack = 1'b1;
      @(posedge clk); #1;
    end
    rsp_ack = 1'b0;
    chk("post_ack_rsp_stb", 32'(rsp_stb), 32'd0);
    chk("post_ack_req_ack", 32'(req_ack), 32'd1);
  endtask

  task automatic slow_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] z, input int da, input int db, input int dz, input int hold);
    int          u;
    logic [4:0]  m;
    logic [31:0] eb;
    u  = (op <= 4'd1) ? 0 : int'(op) - 1;
    m  = 5'(1 << u);
    eb = (op == 4'd1) ? (b ^ 32'h8000_0000) : b;
    @(negedge clk);
    chk("idle_req_ack", 32'(req_ack), 32'd1);
    req_op = op; req_a = a; req_b = b; req_stb = 1'b1;
    @(posedge clk); #1;
    req_stb = 1'b0; req_a = $urandom; req_b = $urandom;
    for (int k = 0; k <= da; k++) begin
      chk("a_stb", 32'(unit_a_stb), 32'(m));
      chk("b_stb_in_a", 32'(unit_b_stb), 32'd0);
      chk("unit_a", unit_a, a);
      chk("unit_b", unit_b, eb);
      chk("rsp_stb_busy", 32'(rsp_stb), 32'd0);
      unit_a_ack = 5'($urandom) & ~m;
      if (k == da) unit_a_ack = unit_a_ack | m;
      @(posedge clk); #1;
    end
    unit_a_ack = '0;
    if (u < 3) begin
      for (int k = 0; k <= db; k++) begin
        chk("b_stb", 32'(unit_b_stb), 32'(m));
        chk("a_stb_in_b", 32'(unit_a_stb), 32'd0);
        unit_b_ack = 5'($urandom) & ~m;
        if (k == db) unit_b_ack = unit_b_ack | m;
        @(posedge clk); #1;
      end
      unit_b_ack = '0;
    end
    for (int k = 0; k <= dz; k++) begin
      chk("z_ack", 32'(unit_z_ack), 32'(m));
      chk("a_stb_in_z", 32'(unit_a_stb), 32'd0);
      chk("b_stb_in_z", 32'(unit_b_stb), 32'd0);
      unit_z = {$urandom, $urandom, $urandom, $urandom, $urandom};
      unit_z_stb = 5'($urandom) & ~m;
      if (k == dz) begin
        unit_z[u*32 +: 32] = z;
        unit_z_stb = unit_z_stb | m;
      end
      @(posedge clk); #1;
    end
    unit_z_stb = '0;
    unit_z = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k <= hold; k++) begin
      chk("slow_rsp_stb", 32'(rsp_stb), 32'd1);
      chk("slow_data", rsp_data, z);
      chk("slow_flags", 32'(rsp_flags), 32'd0);
      chk("resp_z_ack", 32'(unit_z_ack), 32'd0);
      if (k == hold) rsp_ack = 1'b1;
      @(posedge clk); #1;
    end
    rsp_ack = 1'b0;
    chk("post_ack_rsp_stb", 32'(rsp_stb), 32'd0);
    chk("post_ack_req_ack", 32'(req_ack), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ack"}, 32'(req_ack), 32'd1);
    chk({tag, "_rsp_stb"}, 32'(rsp_stb), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
    chk({tag, "_a_stb"}, 32'(unit_a_stb), 32'd0);
    chk({tag, "_b_stb"}, 32'(unit_b_stb), 32'd0);
    chk({tag, "_z_ack"}, 32'(unit_z_ack), 32'd0);
    chk({tag, "_unit_a"}, unit_a, 32'd0);
    chk({tag, "_unit_b"}, unit_b, 32'd0);
  endtask

  logic [3:0] fast_ops [10] = '{4'b0110, 4'b0111, 4'b1110, 4'b1000, 4'b1001,
                                4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1111};

  initial begin
    logic [31:0] ra, rb;
    reset_n = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_stb = 1'b0; rsp_ack = 1'b0;
    unit_a_ack = '0; unit_b_ack = '0; unit_z_stb = '0; unit_z = '0;
    r3_op = '0; r3_a = '0; r3_b = '0; r3_stb = 1'b0; r3_rsp_ack = 1'b0;
    r3_uaa = '0; r3_uba = '0; r3_uzs = '0; r3_uz = '0;
    #2;
    chk_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Directed cases
    fast_txn(4'b1000, 32'h0000_0000, 32'h8000_0000, 0);
    fast_txn(4'b1001, 32'h7FC0_0000, 32'h3F80_0000, 1);
    fast_txn(4'b1010, 32'h3F80_0000, 32'h4000_0000, 0);
    fast_txn(4'b1011, 32'h7F80_0001, 32'h4040_0000, 0);
    fast_txn(4'b1100, 32'h7FC0_0000, 32'hFFC0_0001, 0);
    fast_txn(4'b1011, 32'h0000_0000, 32'h8000_0000, 0);
    fast_txn(4'b1100, 32'h8000_0000, 32'h0000_0000, 0);
    fast_txn(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    slow_txn(4'b0001, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 2, 1, 4, 3);
    slow_txn(4'b0101, 32'h4120_0000, 32'hDEAD_BEEF, 32'h0000_000A, 1, 0, 2, 0);

    // Units missing on the 3-unit instance
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      r3_op = (i == 0) ? 4'b0100 : 4'b0101; r3_a = $urandom; r3_b = $urandom; r3_stb = 1'b1;
      @(posedge clk); #1;
      r3_stb = 1'b0;
      chk("nu3_rsp_stb", 32'(r3_rsp_stb), 32'd1);
      chk("nu3_data", r3_data, 32'd0);
      chk("nu3_flags", 32'(r3_flags), 32'd3);
      chk("nu3_a_stb", 32'(r3_uas), 32'd0);
      r3_rsp_ack = 1'b1;
      @(posedge clk); #1;
      r3_rsp_ack = 1'b0;
      chk("nu3_post_ack", 32'(r3_rsp_stb), 32'd0);
    end

    // Random fast ops
    for (int n = 0; n < 80; n++) begin
      ra = pick_operand();
      rb = ($urandom_range(0, 5) == 0) ? (ra ^ {$urandom_range(0, 1) == 1, 31'd0}) : pick_operand();
      fast_txn(fast_ops[$urandom_range(0, 9)], ra, rb, $urandom_range(0, 2));
    end

    // Random slow ops
    for (int n = 0; n < 20; n++)
      slow_txn(4'($urandom_range(0, 5)), $urandom, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2));

    // Reset while a unit result is outstanding
    @(negedge clk);
    req_op = 4'b0000; req_a = 32'h3F80_0000; req_b = 32'h3F80_0000; req_stb = 1'b1;
    @(posedge clk); #1;
    req_stb = 1'b0; unit_a_ack = 5'b00001;
    @(posedge clk); #1;
    unit_a_ack = '0; unit_b_ack = 5'b00001;
    @(posedge clk); #1;
    unit_b_ack = '0;
    chk("pre_reset_z_ack", 32'(unit_z_ack), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_outputs("midop_reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_reset_req_ack", 32'(req_ack), 32'd1);
    fast_txn(4'b1101, 32'hFF80_0000, 32'h0000_0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
